// File: rtl/microroc_chain_daq_ctrl.sv
// microroc_chain_daq_ctrl
// Multi-chain acquisition/readout sequencer for Microroc ASIC daisy-chains.
// Each cycle does ASIC reset, power-up settle, acquisition, then round-robin
// readout of every enabled chain (lowest index first), with a per-chain
// readout timeout and a completed-cycle counter.
//
// Handshake with each chain: start_readout[i] is a one-cycle request; the
// chain answers with a rising edge on end_readout[i]. Only a 0->1 transition
// seen while waiting counts; a level already high when the request goes out
// is ignored until it falls and rises again. No back-pressure exists.
//
// Optional build macro: MICROROC_TIMEOUT_AUTOMASK_EN
//   defined   : chains with a set timeout_flag are dropped from the enable
//               mask at every re-latch until start goes 0 then 1.
//   undefined : the enable mask is re-latched straight from chain_en.
//
// state_dbg exposes the FSM state register for checkers:
//   0 IDLE, 1 RESET, 2 PWRUP, 3 ACQ, 4 RDSEL, 5 RDSTART, 6 RDWAIT, 7 DONE.
module microroc_chain_daq_ctrl #(
  parameter int N_CHAIN     = 4,
  parameter int ACQ_W       = 16,
  parameter int RST_CYC     = 8,
  parameter int PWR_SETTLE  = 40,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               Clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_CHAIN-1:0] chain_en,
  input  logic [ACQ_W-1:0]   acq_time,
  input  logic               powpulsing_en,
  input  logic [N_CHAIN-1:0] chipsatb,
  input  logic [N_CHAIN-1:0] end_readout,
  output logic               reset_b,
  output logic               start_acq,
  output logic [N_CHAIN-1:0] start_readout,
  output logic               pwr_on_a,
  output logic               pwr_on_adc,
  output logic               pwr_on_dac,
  output logic               pwr_on_d,
  output logic               busy,
  output logic               cycle_done,
  output logic [N_CHAIN-1:0] timeout_flag,
  output logic [15:0]        cycle_count,
  output logic [2:0]         state_dbg
);

  localparam int IDX_W   = (N_CHAIN > 1) ? $clog2(N_CHAIN) : 1;
  localparam int SEQ_MAX = (RST_CYC > PWR_SETTLE) ? RST_CYC : PWR_SETTLE;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

  // Terminal counts: RESET leaves after RST_CYC low cycles (counter starts at
  // 0 on the first RESET cycle), PWRUP after PWR_SETTLE cycles, RDWAIT when
  // TIMEOUT_CYC cycles have elapsed since the RDSTART entry edge.
  localparam logic [SEQ_W-1:0] RST_LAST    = SEQ_W'(RST_CYC);
  localparam logic [SEQ_W-1:0] SETTLE_LAST = SEQ_W'(PWR_SETTLE - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_PWRUP   = 3'd2,
    S_ACQ     = 3'd3,
    S_RDSEL   = 3'd4,
    S_RDSTART = 3'd5,
    S_RDWAIT  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SEQ_W-1:0]   seq_cnt;
  logic [ACQ_W-1:0]   acq_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [N_CHAIN-1:0] en_q;
  logic [N_CHAIN-1:0] read_mask;
  logic [N_CHAIN-1:0] end_q;
  logic [IDX_W-1:0]   rd_idx;
  logic               start_q;

  logic [ACQ_W-1:0]   acq_limit;
  logic               sat_hit;
  logic [N_CHAIN-1:0] pending;
  logic [N_CHAIN-1:0] sel_onehot;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               rd_edge;
  logic               rd_timeout;
  logic [N_CHAIN-1:0] relatch_en;
  logic               start_rise;
  logic               pw_analog;
  logic               pw_digital;

  assign state_dbg = state;

  // Mask used when the enable set is re-latched without a fresh start edge.
`ifdef MICROROC_TIMEOUT_AUTOMASK_EN
  assign relatch_en = chain_en & ~timeout_flag;
`else
  assign relatch_en = chain_en;
`endif

  // Readout selection, acquisition exit, readout completion and next state.
  always_comb begin
    acq_limit  = (acq_time == '0) ? ACQ_W'(1) : acq_time;
    sat_hit    = |(~chipsatb & en_q);
    pending    = en_q & ~read_mask;
    sel_onehot = pending & (~pending + N_CHAIN'(1));
    sel_found  = |pending;
    sel_idx    = '0;
    for (int i = 0; i < N_CHAIN; i++) begin
      if (sel_onehot[i]) sel_idx = IDX_W'(i);
    end
    rd_edge    = end_readout[rd_idx] & ~end_q[rd_idx];
    rd_timeout = (to_cnt >= TO_LAST);
    start_rise = start & ~start_q;

    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_RESET;
      S_RESET:   if (seq_cnt == RST_LAST) state_nxt = powpulsing_en ? S_PWRUP : S_ACQ;
      S_PWRUP:   if (!powpulsing_en || seq_cnt == SETTLE_LAST) state_nxt = S_ACQ;
      S_ACQ:     if (acq_cnt >= acq_limit || sat_hit) state_nxt = S_RDSEL;
      S_RDSEL:   state_nxt = sel_found ? S_RDSTART : S_DONE;
      S_RDSTART: state_nxt = S_RDWAIT;
      S_RDWAIT:  if (rd_edge || rd_timeout) state_nxt = S_RDSEL;
      S_DONE:    state_nxt = start ? S_RESET : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase

    // Power rails follow the state being entered so they are registered.
    pw_analog  = !powpulsing_en || state_nxt == S_PWRUP || state_nxt == S_ACQ;
    pw_digital = !powpulsing_en || state_nxt == S_PWRUP || state_nxt == S_ACQ ||
                 state_nxt == S_RDSEL || state_nxt == S_RDSTART || state_nxt == S_RDWAIT;
  end

  // Sequencer: state, counters, bookkeeping and all registered outputs.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      seq_cnt       <= '0;
      acq_cnt       <= '0;
      to_cnt        <= '0;
      en_q          <= '0;
      read_mask     <= '0;
      end_q         <= '0;
      rd_idx        <= '0;
      start_q       <= 1'b0;
      reset_b       <= 1'b1;
      start_acq     <= 1'b0;
      start_readout <= '0;
      pwr_on_a      <= 1'b0;
      pwr_on_adc    <= 1'b0;
      pwr_on_dac    <= 1'b0;
      pwr_on_d      <= 1'b0;
      busy          <= 1'b0;
      cycle_done    <= 1'b0;
      timeout_flag  <= '0;
      cycle_count   <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      end_q   <= end_readout;

      // Shared sequence counter for RESET and PWRUP dwell times.
      if (state_nxt == state && (state == S_RESET || state == S_PWRUP))
        seq_cnt <= seq_cnt + SEQ_W'(1);
      else
        seq_cnt <= '0;

      // acq_cnt holds the number of cycles start_acq has been high.
      if (state_nxt == S_ACQ && state != S_ACQ)
        acq_cnt <= ACQ_W'(1);
      else if (state == S_ACQ && state_nxt == S_ACQ)
        acq_cnt <= acq_cnt + ACQ_W'(1);

      // Readout timeout runs from the RDSTART entry edge.
      if (state_nxt == S_RDSTART)
        to_cnt <= '0;
      else if (state == S_RDSTART || (state == S_RDWAIT && state_nxt == S_RDWAIT))
        to_cnt <= to_cnt + TO_W'(1);

      // Enable mask latch at cycle start; a fresh start edge clears timeouts.
      if (state == S_IDLE && start) begin
        en_q <= start_rise ? chain_en : relatch_en;
      end else if (state == S_DONE && start) begin
        en_q <= relatch_en;
      end

      if (state == S_IDLE && start_rise) begin
        timeout_flag <= '0;
      end else if (state == S_RDWAIT && rd_timeout && !rd_edge) begin
        timeout_flag[rd_idx] <= 1'b1;
      end

      // Chains already served in this cycle.
      if (state_nxt == S_RESET) begin
        read_mask <= '0;
      end else if (state == S_RDSEL && sel_found) begin
        read_mask <= read_mask | sel_onehot;
        rd_idx    <= sel_idx;
      end

      reset_b       <= !(state == S_RESET && state_nxt == S_RESET);
      start_acq     <= (state_nxt == S_ACQ);
      start_readout <= (state_nxt == S_RDSTART) ? sel_onehot : '0;
      busy          <= (state_nxt != S_IDLE);
      cycle_done    <= (state_nxt == S_DONE);
      pwr_on_a      <= pw_analog;
      pwr_on_adc    <= pw_analog;
      pwr_on_dac    <= pw_analog;
      pwr_on_d      <= pw_digital;

      if (state_nxt == S_DONE && state != S_DONE)
        cycle_count <= cycle_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_microroc_chain_daq_ctrl.sv
// tb_microroc_chain_daq_ctrl
// Directed scenarios against microroc_chain_daq_ctrl (TIMEOUT_CYC=100).
// Drivers push expected output events into exp_q; the monitor turns DUT
// output activity into events and compares them in order.
// Event word: {type[7:0], value[23:0]}.
module tb_microroc_chain_daq_ctrl;

  localparam int N = 4;

  localparam logic [7:0] E_RST  = 8'd1; // reset_b low length
  localparam logic [7:0] E_SET  = 8'd2; // cycles from pwr_on_a rise to start_acq rise
  localparam logic [7:0] E_ACQ  = 8'd3; // start_acq high length
  localparam logic [7:0] E_RD   = 8'd4; // {len[15:8], vector[7:0]} of a start_readout pulse
  localparam logic [7:0] E_TO   = 8'd5; // {chain[23:16], cycles since its start_readout}
  localparam logic [7:0] E_DONE = 8'd6; // {len[23:16], cycle_count[15:0]}

  logic           Clk;
  logic           reset_n;
  logic           start;
  logic [N-1:0]   chain_en;
  logic [15:0]    acq_time;
  logic           powpulsing_en;
  logic [N-1:0]   chipsatb;
  logic [N-1:0]   end_readout;
  logic           reset_b;
  logic           start_acq;
  logic [N-1:0]   start_readout;
  logic           pwr_on_a, pwr_on_adc, pwr_on_dac, pwr_on_d;
  logic           busy;
  logic           cycle_done;
  logic [N-1:0]   timeout_flag;
  logic [15:0]    cycle_count;
  logic [2:0]     state_dbg;

  logic [N-1:0]   auto_en;
  logic [N-1:0]   auto_end;
  logic [N-1:0]   man_end;

  logic [31:0]    exp_q[$];
  int             checks = 0;
  int             errors = 0;
  int             done_cnt = 0;
  int             pwr_off_cnt = 0;

  assign end_readout = auto_end | man_end;

  microroc_chain_daq_ctrl #(
    .N_CHAIN(N), .ACQ_W(16), .RST_CYC(8), .PWR_SETTLE(40), .TIMEOUT_CYC(100)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .start(start), .chain_en(chain_en),
    .acq_time(acq_time), .powpulsing_en(powpulsing_en), .chipsatb(chipsatb),
    .end_readout(end_readout), .reset_b(reset_b), .start_acq(start_acq),
    .start_readout(start_readout), .pwr_on_a(pwr_on_a), .pwr_on_adc(pwr_on_adc),
    .pwr_on_dac(pwr_on_dac), .pwr_on_d(pwr_on_d), .busy(busy),
    .cycle_done(cycle_done), .timeout_flag(timeout_flag),
    .cycle_count(cycle_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] out_vec();
    return {reset_b, start_acq, start_readout, pwr_on_a, pwr_on_adc, pwr_on_dac,
            pwr_on_d, busy, cycle_done, timeout_flag, cycle_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] t, input int v);
    exp_q.push_back({t, v[23:0]});
  endtask

  task automatic emit(input logic [7:0] t, input int v);
    logic [31:0] got;
    logic [31:0] want;
    got = {t, v[23:0]};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event_unexpected: got %h expected none", got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL event: got %h expected %h", got, want);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (!cycle_done && n < budget);
    if (!cycle_done) begin
      checks++; errors++;
      $display("FAIL wait_done: got timeout after %0d cycles expected cycle_done", n);
    end
  endtask

  task automatic wait_acq(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (!start_acq && n < budget);
    if (!start_acq) begin
      checks++; errors++;
      $display("FAIL wait_acq: got timeout after %0d cycles expected start_acq", n);
    end
  endtask

  task automatic wait_rd(input int ch, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (!start_readout[ch] && n < budget);
    if (!start_readout[ch]) begin
      checks++; errors++;
      $display("FAIL wait_rd%0d: got timeout after %0d cycles expected start_readout", ch, n);
    end
  endtask

  // ---------------- chain responder ----------------
  // Enabled chains raise end_readout 4 samples after the request, for 3 cycles.
  initial begin
    int resp_cnt[N];
    int hold[N];
    auto_end = '0;
    for (int i = 0; i < N; i++) begin resp_cnt[i] = 0; hold[i] = 0; end
    forever begin
      @(posedge Clk); #2;
      for (int i = 0; i < N; i++) begin
        if (!reset_n) begin
          resp_cnt[i] = 0; hold[i] = 0; auto_end[i] = 1'b0;
        end else begin
          if (resp_cnt[i] > 0) begin
            resp_cnt[i]--;
            if (resp_cnt[i] == 0) begin auto_end[i] = 1'b1; hold[i] = 3; end
          end else if (hold[i] > 0) begin
            hold[i]--;
            if (hold[i] == 0) auto_end[i] = 1'b0;
          end
          if (start_readout[i] && auto_en[i]) resp_cnt[i] = 4;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int cyc, rst_len, settle, acq_len, rd_len, done_len;
    int rd_at[N];
    logic [N-1:0] rd_vec, p_sr, p_to;
    logic p_reset_b, p_pwr_a, p_start_acq, p_done;
    cyc = 0; rst_len = 0; settle = 0; acq_len = 0; rd_len = 0; done_len = 0;
    rd_vec = '0; p_sr = '0; p_to = '0;
    p_reset_b = 1'b1; p_pwr_a = 1'b0; p_start_acq = 1'b0; p_done = 1'b0;
    for (int i = 0; i < N; i++) rd_at[i] = 0;
    forever begin
      @(posedge Clk); #1;
      cyc++;
      if (!reset_n) begin
        rst_len = 0; settle = 0; acq_len = 0; rd_len = 0; done_len = 0; rd_vec = '0;
      end else begin
        if (!reset_b) rst_len++;
        else if (!p_reset_b) begin emit(E_RST, rst_len); rst_len = 0; end

        if (pwr_on_a && !p_pwr_a) settle = 0;
        else if (pwr_on_a) settle++;
        if (start_acq && !p_start_acq && powpulsing_en) emit(E_SET, settle);

        if (start_acq) acq_len++;
        else if (p_start_acq) begin emit(E_ACQ, acq_len); acq_len = 0; end

        for (int i = 0; i < N; i++)
          if (start_readout[i] && !p_sr[i]) rd_at[i] = cyc;
        if (start_readout != '0) begin
          rd_len++; rd_vec = rd_vec | start_readout;
        end else if (rd_len != 0) begin
          emit(E_RD, (rd_len << 8) | int'(rd_vec)); rd_len = 0; rd_vec = '0;
        end

        for (int i = 0; i < N; i++)
          if (timeout_flag[i] && !p_to[i]) emit(E_TO, (i << 16) | (cyc - rd_at[i]));

        if (cycle_done) begin
          done_len++;
          if (!p_done) done_cnt++;
        end else if (p_done) begin
          emit(E_DONE, (done_len << 16) | int'(cycle_count)); done_len = 0;
        end

        if ({pwr_on_a, pwr_on_adc, pwr_on_dac, pwr_on_d} != 4'hF) pwr_off_cnt++;
      end
      p_reset_b = reset_b; p_pwr_a = pwr_on_a; p_start_acq = start_acq;
      p_sr = start_readout; p_to = timeout_flag; p_done = cycle_done;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    reset_n = 1'b0; start = 1'b0; chain_en = '0; acq_time = 16'd10;
    powpulsing_en = 1'b1; chipsatb = '1; man_end = '0; auto_en = 4'hF;
    repeat (3) @(posedge Clk); #1;
    check("reset_values", out_vec(), 32'h8000_0000);
    @(negedge Clk) reset_n = 1'b1;
    repeat (2) @(posedge Clk);

    // S1: two chains, full acquisition, power pulsing
    push(E_RST, 8); push(E_SET, 40); push(E_ACQ, 10);
    push(E_RD, 'h101); push(E_RD, 'h104); push(E_DONE, (1 << 16) | 1);
    chain_en = 4'b0101;
    @(negedge Clk) start = 1'b1;
    @(posedge Clk); #1;
    check("latency_edge_k", {30'd0, reset_b, busy}, 32'd3);
    @(posedge Clk); #1;
    check("latency_edge_k1", {30'd0, reset_b, busy}, 32'd1);
    wait_done(1000);
    start = 1'b0;
    repeat (2) @(posedge Clk); #1;
    check("idle_pwr_off", {27'd0, pwr_on_a, pwr_on_adc, pwr_on_dac, pwr_on_d, busy}, 32'd0);

    // S2: chain 1 saturates on ACQ cycle 3
    push(E_RST, 8); push(E_SET, 40); push(E_ACQ, 3);
    push(E_RD, 'h102); push(E_DONE, (1 << 16) | 2);
    chain_en = 4'b0010;
    @(negedge Clk) start = 1'b1;
    wait_acq(1000);
    repeat (2) @(posedge Clk); #1 chipsatb = 4'b1101;
    @(posedge Clk); #1 chipsatb = 4'b1111;
    start = 1'b0;
    wait_done(1000);

    // S3: same saturation on a disabled chain is ignored
    push(E_RST, 8); push(E_SET, 40); push(E_ACQ, 10);
    push(E_RD, 'h101); push(E_DONE, (1 << 16) | 3);
    chain_en = 4'b0001;
    @(negedge Clk) start = 1'b1;
    wait_acq(1000);
    repeat (2) @(posedge Clk); #1 chipsatb = 4'b1101;
    @(posedge Clk); #1 chipsatb = 4'b1111;
    start = 1'b0;
    wait_done(1000);
    repeat (2) @(posedge Clk);

    // S4: chain 2 never answers; two back-to-back cycles
    auto_en = 4'b1011;
    chain_en = 4'b1100;
    push(E_RST, 8); push(E_SET, 40); push(E_ACQ, 10);
    push(E_RD, 'h104); push(E_TO, (2 << 16) | 100); push(E_RD, 'h108);
    push(E_DONE, (1 << 16) | 4);
    push(E_RST, 8); push(E_SET, 40); push(E_ACQ, 10);
`ifndef MICROROC_TIMEOUT_AUTOMASK_EN
    push(E_RD, 'h104);
`endif
    push(E_RD, 'h108); push(E_DONE, (1 << 16) | 5);
    @(negedge Clk) start = 1'b1;
    wait_done(1000);
    wait_done(1000);
    start = 1'b0;
    repeat (2) @(posedge Clk); #1;
    check("timeout_sticky", {28'd0, timeout_flag}, 32'h4);

    // S5: fresh start clears the flag; end edge on the timeout cycle wins
    chain_en = 4'b0100;
    push(E_RST, 8); push(E_SET, 40); push(E_ACQ, 10);
    push(E_RD, 'h104); push(E_DONE, (1 << 16) | 6);
    @(negedge Clk) start = 1'b1;
    repeat (2) @(posedge Clk); #1;
    check("timeout_clear", {28'd0, timeout_flag}, 32'h0);
    wait_rd(2, 1000);
    start = 1'b0;
    repeat (99) @(posedge Clk);
    #1 man_end[2] = 1'b1;
    wait_done(1000);
    check("edge_beats_timeout", {28'd0, timeout_flag}, 32'h0);
    man_end = '0;

    // S6: no chains enabled, supplies always on
    @(negedge Clk) powpulsing_en = 1'b0;
    repeat (2) @(posedge Clk); #1;
    check("idle_pwr_on", {28'd0, pwr_on_a, pwr_on_adc, pwr_on_dac, pwr_on_d}, 32'hF);
    pwr_off_cnt = 0;
    chain_en = 4'b0000;
    push(E_RST, 8); push(E_ACQ, 10); push(E_DONE, (1 << 16) | 7);
    @(negedge Clk) start = 1'b1;
    wait_done(1000);
    start = 1'b0;
    repeat (3) @(posedge Clk); #1;
    check("pwr_always_on", pwr_off_cnt, 32'd0);

    // S7: end_readout already high when the request goes out
    auto_en = 4'b1110;
    man_end = 4'b0001;
    chain_en = 4'b0001;
    push(E_RST, 8); push(E_ACQ, 10); push(E_RD, 'h101); push(E_DONE, (1 << 16) | 8);
    @(negedge Clk) start = 1'b1;
    wait_rd(0, 1000);
    start = 1'b0;
    d0 = done_cnt;
    repeat (20) @(posedge Clk); #1;
    check("high_level_waits", {29'd0, state_dbg}, 32'd6);
    check("high_level_no_done", done_cnt, d0);
    man_end[0] = 1'b0;
    repeat (3) @(posedge Clk); #1 man_end[0] = 1'b1;
    wait_done(1000);
    check("high_level_no_timeout", {28'd0, timeout_flag}, 32'h0);
    man_end = '0;

    // S8: asynchronous reset in RDWAIT
    push(E_RST, 8); push(E_ACQ, 10); push(E_RD, 'h101);
    @(negedge Clk) start = 1'b1;
    wait_rd(0, 1000);
    start = 1'b0;
    repeat (5) @(posedge Clk); #1;
    check("pre_reset_state", {29'd0, state_dbg}, 32'd6);
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_values", out_vec(), 32'h8000_0000);
    check("async_reset_state", {29'd0, state_dbg}, 32'd0);
    repeat (2) @(negedge Clk);
    reset_n = 1'b1;
    repeat (3) @(posedge Clk); #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microroc_chain_daq_ctrl.md
Name: microroc_chain_daq_ctrl

Overview:
- Parametrised multi-chain acquisition/readout sequencer for Microroc ASIC daisy-chains; generalises the single-chain DAQ control plus readout-channel selection to N_CHAIN chains.
- Runs repeated cycles of ASIC reset, power-up, acquisition, then sequential round-robin readout of every enabled chain.
- Adds a per-chain readout timeout and cycle statistics.
- Sits between the USB command registers and the per-chain Redundancy/RamReadOut logic.

Parameters:
N_CHAIN, 4, number of ASIC readout chains (1..8)
ACQ_W, 16, width of acquisition-time setting
RST_CYC, 8, Clk cycles reset_b is held low at cycle start
PWR_SETTLE, 40, Clk cycles between power-on and start_acq
TIMEOUT_CYC, 1000000, Clk cycles to wait for end_readout per chain

Ports:
Clk  in  1  40 MHz system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  level; 1 = run continuous cycles
chain_en  in  N_CHAIN  chain enable mask, sampled at cycle start
acq_time  in  ACQ_W  maximum start_acq duration in Clk cycles
powpulsing_en  in  1  1 = power pulsing, 0 = supplies always on
chipsatb  in  N_CHAIN  chain memory full, active low
end_readout  in  N_CHAIN  chain readout finished, active high
reset_b  out  1  ASIC digital reset, active low
start_acq  out  1  acquisition window, active high
start_readout  out  N_CHAIN  one-cycle readout start pulse per chain
pwr_on_a, pwr_on_adc, pwr_on_dac, pwr_on_d  out  1 each  power-pulsing controls
busy  out  1  high whenever FSM not in IDLE
cycle_done  out  1  one-cycle pulse at end of each cycle
timeout_flag  out  N_CHAIN  sticky per-chain readout timeout
cycle_count  out  16  completed cycles, wraps 0xFFFF->0

Behaviour:
- All outputs registered. Reset values: reset_b=1, start_acq=0, start_readout=0, all pwr_on_*=0, busy=0, cycle_done=0, timeout_flag=0, cycle_count=0.
- Async reset at any point returns the FSM to IDLE and forces reset values immediately.
- IDLE:
  - On start=1, latch chain_en into en_q and clear timeout_flag if start was 0 the previous cycle, then go to RESET.
  - Latency: start high at edge k gives reset_b=0 at edge k+1.
- RESET: reset_b=0 for RST_CYC cycles, then PWRUP.
- PWRUP: hold PWR_SETTLE cycles, then ACQ. If powpulsing_en=0, skip directly to ACQ.
- ACQ:
  - start_acq=1 with an ACQ_W counter. acq_time=0 is treated as 1.
  - Leave when the counter reaches acq_time, or when any chipsatb[i]=0 with en_q[i]=1 (sampled while start_acq=1).
  - Chipsatb on a disabled chain is ignored.
  - start_acq falls on the transition to RDSEL.
- RDSEL:
  - Select the lowest enabled chain index not yet read in this cycle.
  - If none remain (including en_q=0), go to DONE.
- RDSTART: start_readout[idx]=1 for exactly one cycle, then RDWAIT.
- RDWAIT:
  - Wait for a rising edge of end_readout[idx], detected against a registered copy. A level that is already high at RDSTART does not count.
  - A timeout counter runs from RDSTART. When it reaches TIMEOUT_CYC, set timeout_flag[idx] and advance.
  - If the edge and the timeout occur in the same cycle, the edge wins and the flag stays clear.
  - Then return to RDSEL.
- DONE:
  - cycle_done=1 for one cycle and cycle_count+1.
  - If start=1, go to RESET with en_q re-latched; otherwise go to IDLE.
  - start falling mid-cycle never aborts the cycle.
- Power rules:
  - powpulsing_en=0: all pwr_on_*=1 from the first edge after reset, in every state including IDLE.
  - powpulsing_en=1: pwr_on_a/adc/dac=1 in PWRUP and ACQ only; pwr_on_d=1 in PWRUP through RDWAIT; all 0 in IDLE, RESET and DONE.
- busy=1 in every state except IDLE.

Optional Feature:
MICROROC_TIMEOUT_AUTOMASK_EN
- Defined: a chain whose timeout_flag is set is cleared from en_q at every re-latch, so it is skipped in later cycles until start goes 0 then 1.
- Undefined: en_q is always re-latched directly from chain_en, and timed-out chains are retried every cycle.

Test Plan:
- Reset then start=1, chain_en=4'b0101, acq_time=10, powpulsing_en=1:
  - reset_b low for 8 cycles, then 40 settle cycles, then start_acq high exactly 10 cycles.
  - start_readout[0] pulses, then start_readout[2] after end_readout[0] rises.
  - cycle_done pulses once and cycle_count=1.
- chipsatb[1]=0 on cycle 3 of ACQ with chain_en=4'b0010: start_acq drops after cycle 3 and chain 1 is read. With chain_en=4'b0001 the same stimulus is ignored and ACQ runs the full 10 cycles.
- Chain 2 never raises end_readout (TIMEOUT_CYC=100 in bench): timeout_flag[2]=1 at 100 cycles after RDSTART, chain 3 is still read, and the flag clears on the next start 0->1.
- Same as above with MICROROC_TIMEOUT_AUTOMASK_EN defined: the second cycle issues no start_readout[2].
- chain_en=0: cycle goes ACQ->DONE with no start_readout pulse. With powpulsing_en=0 all pwr_on_* stay 1 throughout, including IDLE.
- Assert reset_n=0 during RDWAIT: all outputs return to reset values immediately and busy=0. A start_readout pulse during an already-high end_readout does not complete until end_readout falls and rises again.
